// File: rtl/rvx10_pipe_pkg.sv
// Shared types and constants for the fetch/decode/execute front-end pipeline registers.
package rvx10_pipe_pkg;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic        Jump;
        logic        Branch;
        logic        ALUSrc;
        logic [4:0]  ALUControl;
        logic [31:0] RD1;
        logic [31:0] RD2;
        logic [31:0] PC;
        logic [4:0]  Rs1;
        logic [4:0]  Rs2;
        logic [4:0]  Rd;
        logic [31:0] ImmExt;
        logic [31:0] PCPlus4;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // An all-zero bundle is a no-op in EX: no register, memory or control-flow side effects.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       32'h0,
        pc_plus4: 32'h0,
        valid:    1'b0
    };

endpackage

// File: rtl/pipe_front_regs_if.sv
// Bus between the front-end pipeline registers and the surrounding pipeline.
interface pipe_front_regs_if;
    import rvx10_pipe_pkg::*;

    logic        stall_F;
    logic        stall_D;
    logic        flush_D;
    logic        flush_E;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlus4_D;
    logic        valid_D;
    id_ex_t      idex_D;
    id_ex_t      idex_E;
    logic        valid_E;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output stall_F, stall_D, flush_D, flush_E, PCSrc_E, PCTarget_E, Instr_F, idex_D,
        input  PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, idex_E, valid_E, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall_F, stall_D, flush_D, flush_E, PCSrc_E, PCTarget_E, Instr_F, idex_D,
        output PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, idex_E, valid_E, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that increments while enabled and sticks at all-ones.
module sat_counter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with stall/flush control and hazard event counters.
module pipe_front_regs
    import rvx10_pipe_pkg::*;
(
    input logic              clk,
    input logic              reset,
    pipe_front_regs_if.slave bus
);

    logic [31:0] pc_q, pc_d, pc_plus4;
    if_id_t      ifid_q, ifid_d;
    id_ex_t      idex_q, idex_d;
    logic        valid_e_q, valid_e_d;
    logic        stall_cnt_en;
    logic [31:0] stall_cnt, flush_cnt;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        // Redirect beats stall: a taken branch must never be lost to a hazard hold.
        pc_d = pc_q;
        if (bus.PCSrc_E) begin
            pc_d = bus.PCTarget_E;
        end else if (!bus.stall_F) begin
            pc_d = pc_plus4;
        end

        ifid_d = ifid_q;
        if (bus.flush_D) begin
            ifid_d = IF_ID_BUBBLE;
        end else if (!bus.stall_D) begin
            ifid_d = '{instr: bus.Instr_F, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};
        end

        idex_d    = bus.idex_D;
        valid_e_d = ifid_q.valid;
        if (bus.flush_E) begin
            idex_d    = ID_EX_BUBBLE;
            valid_e_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ifid_q    <= IF_ID_BUBBLE;
            idex_q    <= ID_EX_BUBBLE;
            valid_e_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ifid_q    <= ifid_d;
            idex_q    <= idex_d;
            valid_e_q <= valid_e_d;
        end
    end

    // A stall cycle that coincides with a redirect is attributed to the redirect only.
    assign stall_cnt_en = bus.stall_D && !bus.flush_D && !bus.PCSrc_E;

    sat_counter32 u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_cnt_en),
        .count (stall_cnt)
    );

    sat_counter32 u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bus.PCSrc_E),
        .count (flush_cnt)
    );

    assign bus.PC_F      = pc_q;
    assign bus.Instr_D   = ifid_q.instr;
    assign bus.PC_D      = ifid_q.pc;
    assign bus.PCPlus4_D = ifid_q.pc_plus4;
    assign bus.valid_D   = ifid_q.valid;
    assign bus.idex_E    = idex_q;
    assign bus.valid_E   = valid_e_q;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: reset, free-run, load-use, redirect, conflicts, wrap, saturation.
module tb_pipe_front_regs;
    import rvx10_pipe_pkg::*;

    logic clk;
    logic reset;
    int   passed;
    int   total;
    id_ex_t pat;

    pipe_front_regs_if bus ();

    pipe_front_regs dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // IMEM stand-in: each fetched word is tagged with its own address.
    assign bus.Instr_F = bus.PC_F | 32'hC0DE_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctrl();
        bus.stall_F    = 1'b0;
        bus.stall_D    = 1'b0;
        bus.flush_D    = 1'b0;
        bus.flush_E    = 1'b0;
        bus.PCSrc_E    = 1'b0;
        bus.PCTarget_E = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_ctrl();
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'h0000_0500;
        bus.idex_D     = pat;
        step();
        step();
        clear_ctrl();
        reset = 1'b0;
        total++; if (bus.PC_F !== 32'h0) $display("FAIL reset_pc: got %h want %h", bus.PC_F, 32'h0); else passed++;
        total++; if (bus.Instr_D !== 32'h13) $display("FAIL reset_instr_d: got %h want %h", bus.Instr_D, 32'h13); else passed++;
        total++; if (bus.valid_D !== 1'b0 || bus.PC_D !== 32'h0 || bus.PCPlus4_D !== 32'h0)
            $display("FAIL reset_ifid: got v=%b pc=%h p4=%h want v=0 pc=0 p4=0", bus.valid_D, bus.PC_D, bus.PCPlus4_D);
        else passed++;
        total++; if (bus.valid_E !== 1'b0 || bus.idex_E !== ID_EX_BUBBLE)
            $display("FAIL reset_idex: got v=%b idex=%h want v=0 idex=0", bus.valid_E, bus.idex_E);
        else passed++;
        total++; if (bus.stall_cnt !== 32'h0 || bus.flush_cnt !== 32'h0)
            $display("FAIL reset_cnt: got %h/%h want 0/0", bus.stall_cnt, bus.flush_cnt);
        else passed++;
    endtask

    task automatic test_free_run();
        step();
        total++; if (bus.PC_F !== 32'h4) $display("FAIL run_pc4: got %h want %h", bus.PC_F, 32'h4); else passed++;
        total++; if (bus.Instr_D !== 32'hC0DE_0000 || bus.PC_D !== 32'h0 || bus.PCPlus4_D !== 32'h4 || bus.valid_D !== 1'b1)
            $display("FAIL run_ifid0: got i=%h pc=%h p4=%h v=%b want i=c0de0000 pc=0 p4=4 v=1",
                     bus.Instr_D, bus.PC_D, bus.PCPlus4_D, bus.valid_D);
        else passed++;
        step();
        total++; if (bus.PC_F !== 32'h8) $display("FAIL run_pc8: got %h want %h", bus.PC_F, 32'h8); else passed++;
        total++; if (bus.Instr_D !== 32'hC0DE_0004) $display("FAIL run_instr4: got %h want %h", bus.Instr_D, 32'hC0DE_0004); else passed++;
        total++; if (bus.valid_E !== 1'b1 || bus.idex_E !== pat)
            $display("FAIL run_idex: got v=%b idex=%h want v=1 idex=%h", bus.valid_E, bus.idex_E, pat);
        else passed++;
        step();
        total++; if (bus.PC_F !== 32'hC) $display("FAIL run_pc12: got %h want %h", bus.PC_F, 32'hC); else passed++;
        step();
    endtask

    task automatic test_load_use();
        total++; if (bus.PC_F !== 32'h10) $display("FAIL lu_setup_pc: got %h want %h", bus.PC_F, 32'h10); else passed++;
        bus.stall_F = 1'b1;
        bus.stall_D = 1'b1;
        bus.flush_E = 1'b1;
        step();
        clear_ctrl();
        total++; if (bus.PC_F !== 32'h10) $display("FAIL lu_pc_hold: got %h want %h", bus.PC_F, 32'h10); else passed++;
        total++; if (bus.Instr_D !== 32'hC0DE_000C) $display("FAIL lu_instr_hold: got %h want %h", bus.Instr_D, 32'hC0DE_000C); else passed++;
        total++; if (bus.valid_E !== 1'b0 || bus.idex_E.RegWrite !== 1'b0)
            $display("FAIL lu_bubble: got v=%b rw=%b want v=0 rw=0", bus.valid_E, bus.idex_E.RegWrite);
        else passed++;
        total++; if (bus.stall_cnt !== 32'h1) $display("FAIL lu_stall_cnt: got %h want %h", bus.stall_cnt, 32'h1); else passed++;
        step();
        total++; if (bus.PC_F !== 32'h14 || bus.Instr_D !== 32'hC0DE_0010 || bus.valid_E !== 1'b1)
            $display("FAIL lu_resume: got pc=%h i=%h ve=%b want pc=14 i=c0de0010 ve=1", bus.PC_F, bus.Instr_D, bus.valid_E);
        else passed++;
    endtask

    task automatic test_redirect();
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'h200;
        bus.flush_D    = 1'b1;
        bus.flush_E    = 1'b1;
        step();
        clear_ctrl();
        total++; if (bus.PC_F !== 32'h200) $display("FAIL rd_pc: got %h want %h", bus.PC_F, 32'h200); else passed++;
        total++; if (bus.Instr_D !== 32'h13 || bus.valid_D !== 1'b0 || bus.PC_D !== 32'h0)
            $display("FAIL rd_ifid: got i=%h v=%b pc=%h want i=13 v=0 pc=0", bus.Instr_D, bus.valid_D, bus.PC_D);
        else passed++;
        total++; if (bus.valid_E !== 1'b0) $display("FAIL rd_valid_e: got %b want 0", bus.valid_E); else passed++;
        total++; if (bus.flush_cnt !== 32'h1) $display("FAIL rd_flush_cnt: got %h want %h", bus.flush_cnt, 32'h1); else passed++;
        step();
        total++; if (bus.PC_F !== 32'h204 || bus.Instr_D !== 32'hC0DE_0200 || bus.valid_D !== 1'b1 || bus.valid_E !== 1'b0)
            $display("FAIL rd_after: got pc=%h i=%h vd=%b ve=%b want pc=204 i=c0de0200 vd=1 ve=0",
                     bus.PC_F, bus.Instr_D, bus.valid_D, bus.valid_E);
        else passed++;
    endtask

    task automatic test_conflict();
        bus.stall_F    = 1'b1;
        bus.stall_D    = 1'b1;
        bus.flush_D    = 1'b1;
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'h40;
        step();
        clear_ctrl();
        total++; if (bus.PC_F !== 32'h40) $display("FAIL cf_pc: got %h want %h", bus.PC_F, 32'h40); else passed++;
        total++; if (bus.Instr_D !== 32'h13 || bus.valid_D !== 1'b0)
            $display("FAIL cf_ifid: got i=%h v=%b want i=13 v=0", bus.Instr_D, bus.valid_D);
        else passed++;
        total++; if (bus.stall_cnt !== 32'h1 || bus.flush_cnt !== 32'h2)
            $display("FAIL cf_cnt: got %h/%h want 1/2", bus.stall_cnt, bus.flush_cnt);
        else passed++;
        step();
        bus.stall_D    = 1'b1;
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'h80;
        step();
        clear_ctrl();
        total++; if (bus.PC_F !== 32'h80 || bus.Instr_D !== 32'hC0DE_0040 || bus.valid_D !== 1'b1)
            $display("FAIL cf_hold: got pc=%h i=%h v=%b want pc=80 i=c0de0040 v=1", bus.PC_F, bus.Instr_D, bus.valid_D);
        else passed++;
        total++; if (bus.stall_cnt !== 32'h1 || bus.flush_cnt !== 32'h3)
            $display("FAIL cf_cnt2: got %h/%h want 1/3", bus.stall_cnt, bus.flush_cnt);
        else passed++;
    endtask

    task automatic test_wrap_sat();
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'hFFFF_FFFC;
        step();
        clear_ctrl();
        total++; if (bus.PC_F !== 32'hFFFF_FFFC) $display("FAIL wr_setup: got %h want %h", bus.PC_F, 32'hFFFF_FFFC); else passed++;
        step();
        total++; if (bus.PC_F !== 32'h0) $display("FAIL wr_pc: got %h want %h", bus.PC_F, 32'h0); else passed++;
        total++; if (bus.Instr_D !== 32'hFFFF_FFFC || bus.PCPlus4_D !== 32'h0)
            $display("FAIL wr_ifid: got i=%h p4=%h want i=fffffffc p4=0", bus.Instr_D, bus.PCPlus4_D);
        else passed++;
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        bus.stall_D = 1'b1;
        step();
        total++; if (bus.stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_reach: got %h want %h", bus.stall_cnt, 32'hFFFF_FFFF); else passed++;
        step();
        step();
        total++; if (bus.stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_hold: got %h want %h", bus.stall_cnt, 32'hFFFF_FFFF); else passed++;
        clear_ctrl();
    endtask

    task automatic test_reset_mid_stall();
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'h80;
        step();
        clear_ctrl();
        bus.stall_F = 1'b1;
        bus.stall_D = 1'b1;
        step();
        total++; if (bus.PC_F !== 32'h80) $display("FAIL rs_setup: got %h want %h", bus.PC_F, 32'h80); else passed++;
        reset          = 1'b1;
        bus.PCSrc_E    = 1'b1;
        bus.PCTarget_E = 32'h300;
        step();
        reset = 1'b0;
        clear_ctrl();
        total++; if (bus.PC_F !== 32'h0 || bus.valid_D !== 1'b0 || bus.valid_E !== 1'b0)
            $display("FAIL rs_state: got pc=%h vd=%b ve=%b want pc=0 vd=0 ve=0", bus.PC_F, bus.valid_D, bus.valid_E);
        else passed++;
        total++; if (bus.stall_cnt !== 32'h0 || bus.flush_cnt !== 32'h0)
            $display("FAIL rs_cnt: got %h/%h want 0/0", bus.stall_cnt, bus.flush_cnt);
        else passed++;
        step();
        total++; if (bus.PC_F !== 32'h4 || bus.Instr_D !== 32'hC0DE_0000 || bus.PC_D !== 32'h0)
            $display("FAIL rs_first_fetch: got pc=%h i=%h pcd=%h want pc=4 i=c0de0000 pcd=0",
                     bus.PC_F, bus.Instr_D, bus.PC_D);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        pat            = '0;
        pat.RegWrite   = 1'b1;
        pat.ResultSrc  = 2'b01;
        pat.Rd         = 5'd7;
        pat.RD1        = 32'h1111_2222;
        pat.ImmExt     = 32'h0000_0010;
        bus.idex_D     = pat;
        clear_ctrl();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_load_use();
        test_redirect();
        test_conflict();
        test_wrap_sat();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
